frame_sequencer: RTL
====================

Name: frame_sequencer

Overview:
Parametrised sample-frame timebase for the multi-effects FPGA. It replaces the hard-wired 833-cycle counter in the top level. It generates the per-frame sample strobe, the RAM write strobe, N independent SPI serial clocks and start windows, and the delay-line write/read addresses. Frame period and delay are runtime-programmable and take effect only on frame boundaries.

Parameters:
PERIOD_W, 10, width of frame counter and period input
DEFAULT_PERIOD, 832, last count value of a frame after reset (frame = DEFAULT_PERIOD+1 clks; 48 kHz at 40 MHz)
MIN_PERIOD, 64, smallest legal period; smaller requests are clamped
NUM_SPI, 2, number of SPI clock/start channels
SCLK_SHIFTS, {4'd5,4'd3}, packed NUM_SPI x 4-bit; channel i sclk = count[SCLK_SHIFTS[i]]
GO_LEN, 512, start window length in clks (spi_go high while count < GO_LEN)
ADDR_W, 13, delay-line address width; depth = 2**ADDR_W

Ports:
clk  in  1  system clock (40 MHz)
reset  in  1  synchronous, active-high reset
enable  in  1  run when high; when low, frame counter holds
period_i  in  PERIOD_W  requested last count value of a frame
delay_i  in  ADDR_W  requested delay in frames (read lag behind write)
count  out  PERIOD_W  current position in frame
frame_start  out  1  one-clk pulse, count==0 and enabled
we  out  1  one-clk pulse on last clk of frame (count==period_q)
sclk  out  NUM_SPI  per-channel serial clock
spi_go  out  NUM_SPI  per-channel transfer window, high while count < GO_LEN
wr_addr  out  ADDR_W  delay-line write address
rd_addr  out  ADDR_W  delay-line read address
period_err  out  1  sticky: a clamped period_i was loaded

Behaviour:
- All state updates on posedge clk. reset has priority over everything.
- Reset values: count=0, period_q=DEFAULT_PERIOD, delay_q=0, wr_addr=0, rd_addr=0, period_err=0. frame_start and we are 0 in the reset cycle. sclk=0. spi_go=0 while reset is high.
- Counter: when enable=1, count increments. When count==period_q, count wraps to 0 next clk. When enable=0, count, addresses and period_q hold. frame_start, we and spi_go are forced 0. sclk holds its current value.
- frame_start = enable && count==0. we = enable && count==period_q. Both are combinational from registered state, so they are valid the same cycle count shows the value.
- Period load: on the we cycle, period_q <= max(period_i, MIN_PERIOD). If period_i < MIN_PERIOD, period_err <= 1; it is cleared only by reset. period_i changes mid-frame have no effect on the current frame.
- Effective frame length is period_q+1 clks. An empty or short frame is impossible.
- Delay load: on the we cycle, delay_q <= delay_i. delay_i is unsigned, and values up to 2**ADDR_W-1 are legal.
- Addresses: on the we cycle, wr_addr <= wr_addr+1, wrapping modulo 2**ADDR_W. rd_addr is registered as (next wr_addr - next delay_q) mod 2**ADDR_W and updates in the same cycle. Both are therefore stable for the whole frame.
- delay_q=0: rd_addr==wr_addr, so the read returns the old sample before the write at frame end.
- sclk[i] = count[SCLK_SHIFTS[i]], combinational. SCLK_SHIFTS[i] must be < PERIOD_W; an out-of-range value is an elaboration-time assertion.
- spi_go[i] = enable && !reset && count < GO_LEN, identical for all channels. It is provided per channel so a later channel-specific window can be added.
- Reset mid-frame: the next cycle shows count=0 and period_q=DEFAULT_PERIOD. No we pulse is emitted for the aborted frame.
- enable falling on the we cycle: we is suppressed and no loads or increments occur. The frame completes after enable returns.

Decomposition:
- Package fx_timing_pkg: DEFAULT_PERIOD, MIN_PERIOD, PERIOD_W, ADDR_W constants; typedef period_t, addr_t.
- Sub-module delay_pointer: owns wr_addr, delay_q and rd_addr. Inputs: advance (=we), delay_i. frame_sequencer instantiates one.

Test Plan:
- Reset then enable=1, period_i=832: frame_start at count 0 every 833 clks; we at count 832; wr_addr 0→1 after the first we.
- period_i changed to 400 at count 100: current frame still ends at 832; next frame's we comes at count 400, 401 clks later.
- period_i=10 loaded: period_q=64, period_err=1 and stays 1 until reset.
- delay_i=3 for 5 frames: after the 5th we, wr_addr=5, rd_addr=2. Run a wrap from wr_addr=8191 with delay 3: wr_addr=0, rd_addr=8189.
- enable=0 for 50 clks at count 200: count holds at 200, no we or frame_start, spi_go=0. Resume: we arrives 50 clks late.
- reset pulse at count 700: next cycle count=0, period_q=832, we not pulsed. Check sclk[0] toggles every 8 clks and sclk[1] every 32 clks.

Source files
------------

// File: rtl/fx_timing_pkg.sv
// -----------------------------------------------------------------------------
// fx_timing_pkg
// Shared timing constants and types for the multi-effects sample-frame timebase.
// The frame counter counts 0..period inclusive, so a frame is period+1 clocks.
// The defaults give a 48 kHz frame from a 40 MHz system clock.
// -----------------------------------------------------------------------------
package fx_timing_pkg;

  localparam int PERIOD_W       = 10;   // frame counter / period width
  localparam int ADDR_W         = 13;   // delay-line address width
  localparam int DEFAULT_PERIOD = 832;  // last count of a frame after reset
  localparam int MIN_PERIOD     = 64;   // smaller period requests are clamped
  localparam int NUM_SPI        = 2;    // SPI clock / start-window channels
  localparam int GO_LEN         = 512;  // start window length in clocks

  // Channel i serial clock is count bit SCLK_SHIFTS[4*i +: 4].
  localparam logic [NUM_SPI*4-1:0] SCLK_SHIFTS = {4'd5, 4'd3};

  typedef logic [PERIOD_W-1:0] period_t;
  typedef logic [ADDR_W-1:0]   addr_t;

endpackage

// File: rtl/delay_pointer.sv
// -----------------------------------------------------------------------------
// delay_pointer
// Delay-line address generator. The write address advances by one per frame;
// the read address trails it by the programmed delay (in frames). Delay and
// both addresses only change on an advance, so they are stable for a frame.
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   advance  in   one-clk pulse on the last clock of a frame
//   delay_i  in   requested delay in frames, captured on advance
//   wr_addr  out  delay-line write address
//   rd_addr  out  delay-line read address = wr_addr - delay (mod 2**ADDR_W)
// -----------------------------------------------------------------------------
module delay_pointer #(
  parameter int ADDR_W = fx_timing_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic [ADDR_W-1:0] delay_i,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr
);

  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_delay_q;
  logic [ADDR_W-1:0] r_rd_addr;

  logic [ADDR_W-1:0] w_wr_next;
  logic [ADDR_W-1:0] w_delay_next;
  logic [ADDR_W-1:0] w_rd_next;

  // NOTE: every signal is given a value on every path through always_comb so
  // no latch can be inferred.
  always_comb begin
    w_wr_next    = r_wr_addr;
    w_delay_next = r_delay_q;
    if (advance) begin
      w_wr_next    = r_wr_addr + ADDR_W'(1);
      w_delay_next = delay_i;
    end
    // Read address is derived from the post-advance values so it moves in
    // the same edge as the write address; modulo arithmetic is the natural
    // unsigned wrap of the subtraction.
    w_rd_next = w_wr_next - w_delay_next;
  end

  // NOTE: sequential state uses non-blocking assignments so each register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_addr <= '0;
      r_delay_q <= '0;
      r_rd_addr <= '0;
    end else begin
      r_wr_addr <= w_wr_next;
      r_delay_q <= w_delay_next;
      r_rd_addr <= w_rd_next;
    end
  end

  assign wr_addr = r_wr_addr;
  assign rd_addr = r_rd_addr;

endmodule

// File: rtl/frame_sequencer.sv
// -----------------------------------------------------------------------------
// frame_sequencer
// Parametrised sample-frame timebase. A frame counter runs 0..period_q; the
// period and delay requests are sampled only on the last clock of a frame,
// so mid-frame changes never shorten or stretch the frame in progress.
//
// Ports:
//   clk          in   system clock (40 MHz)
//   reset        in   synchronous, active-high reset
//   enable       in   run when high; when low the frame counter holds
//   period_i     in   requested last count value of a frame
//   delay_i      in   requested delay-line lag in frames
//   count        out  current position in frame
//   frame_start  out  one-clk pulse at count 0 while enabled
//   we           out  one-clk pulse on the last clock of a frame
//   sclk         out  per-channel serial clock (a bit of count)
//   spi_go       out  per-channel transfer window, high while count < GO_LEN
//   wr_addr      out  delay-line write address
//   rd_addr      out  delay-line read address
//   period_err   out  sticky flag: a clamped period request was loaded
// -----------------------------------------------------------------------------
module frame_sequencer #(
  parameter int                     PERIOD_W       = fx_timing_pkg::PERIOD_W,
  parameter int                     DEFAULT_PERIOD = fx_timing_pkg::DEFAULT_PERIOD,
  parameter int                     MIN_PERIOD     = fx_timing_pkg::MIN_PERIOD,
  parameter int                     NUM_SPI        = fx_timing_pkg::NUM_SPI,
  parameter logic [NUM_SPI*4-1:0]   SCLK_SHIFTS    = fx_timing_pkg::SCLK_SHIFTS,
  parameter int                     GO_LEN         = fx_timing_pkg::GO_LEN,
  parameter int                     ADDR_W         = fx_timing_pkg::ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [ADDR_W-1:0]   delay_i,
  output logic [PERIOD_W-1:0] count,
  output logic                frame_start,
  output logic                we,
  output logic [NUM_SPI-1:0]  sclk,
  output logic [NUM_SPI-1:0]  spi_go,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [ADDR_W-1:0]   rd_addr,
  output logic                period_err
);

  localparam logic [PERIOD_W-1:0] LP_DEFAULT = PERIOD_W'(DEFAULT_PERIOD);
  localparam logic [PERIOD_W-1:0] LP_MIN     = PERIOD_W'(MIN_PERIOD);

  // Elaboration-time parameter sanity.
  if (MIN_PERIOD < 1 || MIN_PERIOD >= (1 << PERIOD_W)) begin : g_bad_min
    $error("frame_sequencer: MIN_PERIOD out of range for PERIOD_W");
  end
  if (DEFAULT_PERIOD < MIN_PERIOD || DEFAULT_PERIOD >= (1 << PERIOD_W)) begin : g_bad_default
    $error("frame_sequencer: DEFAULT_PERIOD out of range");
  end

  logic [PERIOD_W-1:0] r_count;
  logic [PERIOD_W-1:0] r_period_q;
  logic                r_period_err;

  logic                w_run;
  logic                w_we;
  logic                w_clamp;
  logic [PERIOD_W-1:0] w_period_load;
  logic                w_in_go;

  // Outputs are decoded from registered state, so they are valid in the same
  // cycle that count shows the value. Gating with reset keeps the reset cycle
  // free of strobes even though the counter only clears at the next edge.
  assign w_run = enable && !reset;
  assign w_we  = w_run && (r_count == r_period_q);

  always_comb begin
    w_clamp       = (period_i < LP_MIN);
    w_period_load = w_clamp ? LP_MIN : period_i;
  end

  // Frame counter and period register. Loads happen only on the wrap cycle,
  // which already implies enable, so a disabled we cycle loads nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count      <= '0;
      r_period_q   <= LP_DEFAULT;
      r_period_err <= 1'b0;
    end else if (w_we) begin
      r_count    <= '0;
      r_period_q <= w_period_load;
      if (w_clamp) begin
        r_period_err <= 1'b1;
      end
    end else if (enable) begin
      r_count <= r_count + PERIOD_W'(1);
    end
  end

  delay_pointer #(
    .ADDR_W (ADDR_W)
  ) u_delay_pointer (
    .clk     (clk),
    .reset   (reset),
    .advance (w_we),
    .delay_i (delay_i),
    .wr_addr (wr_addr),
    .rd_addr (rd_addr)
  );

  // Start window comparison is done at 32 bits so GO_LEN may exceed the
  // counter range (window then covers the whole frame).
  assign w_in_go = (32'(r_count) < 32'(GO_LEN));

  for (genvar i = 0; i < NUM_SPI; i++) begin : g_spi
    localparam int SHIFT = int'(SCLK_SHIFTS[i*4 +: 4]);
    if (SHIFT >= PERIOD_W) begin : g_bad_shift
      $error("frame_sequencer: SCLK_SHIFTS entry exceeds counter width");
      assign sclk[i] = 1'b0;
    end else begin : g_sclk
      // Holds naturally while disabled because the counter holds.
      assign sclk[i] = r_count[SHIFT];
    end
    // Same window on every channel today; kept per channel for future
    // channel-specific timing.
    assign spi_go[i] = w_run && w_in_go;
  end

  assign count       = r_count;
  assign frame_start = w_run && (r_count == '0);
  assign we          = w_we;
  assign period_err  = r_period_err;

endmodule
